jvm_decode_sequencer: RTL and testbench
=======================================

# jvm_decode_sequencer

Parametrised instruction decode and microcode sequencer for the JVM-to-ARM translation front end. It fetches opcode and operand bytes from instruction RAM with a valid/request handshake. It handles the `wide` prefix by doubling the operand byte count, then walks the microcode address chain through an external next-address ROM until a zero link terminates the instruction. It adds flush, a runaway-iteration watchdog and explicit per-byte operand strobes.

## Interface
Parameters:
- OPC_W, 8, opcode/byte width
- ADR_W, 10, microcode address width (≥ OPC_W)
- PARAM_W, 3, width of operand-count input
- MAX_ITER, 64, max microcode steps per instruction before fault
- WIDE_OPCODE, 8'hC4, wide prefix value

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- waiting  in  1  global stall; freezes all registers
- flush  in  1  abort current instruction (branch taken)
- iram_data  in  OPC_W  byte from instruction RAM
- iram_valid  in  1  iram_data valid this cycle
- iram_req  out  1  byte request (combinational)
- parameter_number  in  PARAM_W  operand bytes for opcode on iram_data (combinational lookup, valid in FETCH)
- next_adr  in  ADR_W  next-address ROM output for com_adr
- state  out  2  FETCH=0, PARAMS=1, ITERATE=2, HALT=3
- com_adr  out  ADR_W  current microcode address
- jvm_opcode  out  OPC_W  latched opcode
- is_wide  out  1  wide prefix active for current instruction
- q_select  out  1  Q_FETCH=0, Q_ITER=1
- param_byte  out  OPC_W  registered operand byte
- param_index  out  PARAM_W+1  index of param_byte (0-based)
- param_byte_valid  out  1  one-cycle strobe
- instr_done  out  1  one-cycle strobe, instruction retired
- error  out  1  sticky watchdog/double-wide fault

## Operation
- Reset: state=FETCH, com_adr=0, jvm_opcode=0, is_wide=0, q_select=0, param_byte=0, param_index=0, param_byte_valid=0, instr_done=0, error=0; internal target/counters 0.
- iram_req = !waiting && !reset && (state==FETCH || state==PARAMS).
- A byte is accepted on an edge where iram_req && iram_valid.
- FETCH, accepting byte b:
  - If b==WIDE_OPCODE and !is_wide: is_wide←1, stay in FETCH.
  - If b==WIDE_OPCODE and is_wide: error←1, go to HALT.
  - Otherwise: jvm_opcode←b; target T←is_wide ? 2·parameter_number : parameter_number (PARAM_W+1 bits, no overflow); param_index←0.
  - If T==0: go to ITERATE, com_adr←zero-extended b, q_select←1.
  - Else: go to PARAMS.
- PARAMS, accepting a byte:
  - param_byte←byte, param_index←count, param_byte_valid←1, count++.
  - On count==T-1: go to ITERATE, com_adr←jvm_opcode zero-extended, q_select←1, iter←0.
- ITERATE, each unstalled edge:
  - If next_adr==0: go to FETCH, q_select←0, is_wide←0, instr_done←1.
  - Else if iter==MAX_ITER-1: error←1, go to HALT.
  - Else: com_adr←next_adr, iter++.
- HALT: absorbing; exits only on reset. iram_req=0.
- flush, not stalled, state≠HALT: go to FETCH; is_wide, count and iter cleared; q_select←0; com_adr and jvm_opcode hold; error holds; no instr_done. flush beats any same-edge byte acceptance.
- Priority: reset > waiting > flush > normal.

## Timing
- param_byte_valid and instr_done are 1 for exactly one cycle after their edge. They are 0 after any stalled edge.
- With no stalls and iram_valid always 1:
  - Opcode with 0 operands and a single microstep: FETCH 1 cycle, ITERATE 1 cycle; instr_done high in cycle 3.
  - Operand bytes: each adds 1 cycle.
  - wide prefix: adds 1 cycle.
  - Microsteps: each additional one adds 1 cycle.
- waiting high: no register changes; iram_req=0; iram_valid is ignored.
- reset asserted mid-instruction: all outputs take reset values on the next edge.

## Test plan
- Reset then byte 8'h60 (0 operands), next_adr=0 → cycle 1 ITERATE com_adr=0x060, cycle 2 instr_done=1, state=FETCH.
- 8'h10 with parameter_number=1, operand 8'h2A → one strobe param_byte=0x2A index 0; then ITERATE com_adr=0x010.
- WIDE, 8'h15, parameter_number=1, operands 0x01,0x02 → is_wide=1; two strobes index 0,1; is_wide cleared with instr_done.
- ROM chain 0x0B6→0x200→0x201→0 → com_adr sequence 0x0B6, 0x200, 0x201; instr_done after 3 ITERATE cycles. A chain looping 0x300→0x300 → error=1, HALT after MAX_ITER steps.
- waiting held 3 cycles during PARAMS and iram_valid toggling → no acceptance; outputs frozen; strobe count unchanged.
- flush in PARAMS after 1 of 2 bytes → state FETCH next cycle; no instr_done; the next opcode decodes normally. Double WIDE → error=1, HALT.

Source files
------------

// File: rtl/jvm_decode_sequencer.sv
// rtl/jvm_decode_sequencer.sv - JVM opcode fetch/decode and microcode address sequencer
module jvm_decode_sequencer #(
    parameter int               OPC_W       = 8,
    parameter int               ADR_W       = 10,
    parameter int               PARAM_W     = 3,
    parameter int               MAX_ITER    = 64,
    parameter logic [OPC_W-1:0] WIDE_OPCODE = 8'hC4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               waiting,
    input  logic               flush,
    input  logic [OPC_W-1:0]   iram_data,
    input  logic               iram_valid,
    output logic               iram_req,
    input  logic [PARAM_W-1:0] parameter_number,
    input  logic [ADR_W-1:0]   next_adr,
    output logic [1:0]         state,
    output logic [ADR_W-1:0]   com_adr,
    output logic [OPC_W-1:0]   jvm_opcode,
    output logic               is_wide,
    output logic               q_select,
    output logic [OPC_W-1:0]   param_byte,
    output logic [PARAM_W:0]   param_index,
    output logic               param_byte_valid,
    output logic               instr_done,
    output logic               error
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_PARAMS  = 2'd1,
        S_ITERATE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam int CNT_W  = PARAM_W + 1;
    // Wide enough to hold MAX_ITER-1 for any MAX_ITER >= 1.
    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    state_t             r_state;
    logic [ADR_W-1:0]   r_com_adr;
    logic [OPC_W-1:0]   r_opcode;
    logic               r_is_wide;
    logic               r_q_select;
    logic [OPC_W-1:0]   r_param_byte;
    logic [CNT_W-1:0]   r_param_index;
    logic               r_pbv;
    logic               r_done;
    logic               r_error;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_count;
    logic [ITER_W-1:0]  r_iter;

    state_t             w_state;
    logic [ADR_W-1:0]   w_com_adr;
    logic [OPC_W-1:0]   w_opcode;
    logic               w_is_wide;
    logic               w_q_select;
    logic [OPC_W-1:0]   w_param_byte;
    logic [CNT_W-1:0]   w_param_index;
    logic               w_pbv;
    logic               w_done;
    logic               w_error;
    logic [CNT_W-1:0]   w_target;
    logic [CNT_W-1:0]   w_count;
    logic [ITER_W-1:0]  w_iter;

    logic               w_accept;
    logic [CNT_W-1:0]   w_tgt_calc;

    assign iram_req = !waiting && !reset && (r_state == S_FETCH || r_state == S_PARAMS);
    assign w_accept = iram_req && iram_valid;

    // Operand byte count for the opcode on the bus; doubled under a wide prefix.
    assign w_tgt_calc = r_is_wide ? {parameter_number, 1'b0} : {1'b0, parameter_number};

    assign state            = r_state;
    assign com_adr          = r_com_adr;
    assign jvm_opcode       = r_opcode;
    assign is_wide          = r_is_wide;
    assign q_select         = r_q_select;
    assign param_byte       = r_param_byte;
    assign param_index      = r_param_index;
    assign param_byte_valid = r_pbv;
    assign instr_done       = r_done;
    assign error            = r_error;

    // Next-state and next-register values; strobes default low so stalls clear them.
    always_comb begin
        w_state       = r_state;
        w_com_adr     = r_com_adr;
        w_opcode      = r_opcode;
        w_is_wide     = r_is_wide;
        w_q_select    = r_q_select;
        w_param_byte  = r_param_byte;
        w_param_index = r_param_index;
        w_pbv         = 1'b0;
        w_done        = 1'b0;
        w_error       = r_error;
        w_target      = r_target;
        w_count       = r_count;
        w_iter        = r_iter;

        if (waiting) begin
            // stall: everything holds except the one-cycle strobes
        end else if (flush && r_state != S_HALT) begin
            w_state    = S_FETCH;
            w_is_wide  = 1'b0;
            w_count    = '0;
            w_iter     = '0;
            w_q_select = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_accept) begin
                        if (iram_data == WIDE_OPCODE) begin
                            if (r_is_wide) begin
                                w_error = 1'b1;
                                w_state = S_HALT;
                            end else begin
                                w_is_wide = 1'b1;
                            end
                        end else begin
                            w_opcode      = iram_data;
                            w_target      = w_tgt_calc;
                            w_param_index = '0;
                            w_count       = '0;
                            w_iter        = '0;
                            if (w_tgt_calc == '0) begin
                                w_state    = S_ITERATE;
                                w_com_adr  = ADR_W'(iram_data);
                                w_q_select = 1'b1;
                            end else begin
                                w_state = S_PARAMS;
                            end
                        end
                    end
                end
                S_PARAMS: begin
                    if (w_accept) begin
                        w_param_byte  = iram_data;
                        w_param_index = r_count;
                        w_pbv         = 1'b1;
                        w_count       = r_count + CNT_W'(1);
                        if (r_count + CNT_W'(1) == r_target) begin
                            w_state    = S_ITERATE;
                            w_com_adr  = ADR_W'(r_opcode);
                            w_q_select = 1'b1;
                            w_iter     = '0;
                        end
                    end
                end
                S_ITERATE: begin
                    if (next_adr == '0) begin
                        w_state    = S_FETCH;
                        w_q_select = 1'b0;
                        w_is_wide  = 1'b0;
                        w_done     = 1'b1;
                    end else if (r_iter == ITER_LAST) begin
                        w_error = 1'b1;
                        w_state = S_HALT;
                    end else begin
                        w_com_adr = next_adr;
                        w_iter    = r_iter + ITER_W'(1);
                    end
                end
                default: begin
                    // HALT is absorbing until reset
                end
            endcase
        end
    end

    // Register update with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_com_adr     <= '0;
            r_opcode      <= '0;
            r_is_wide     <= 1'b0;
            r_q_select    <= 1'b0;
            r_param_byte  <= '0;
            r_param_index <= '0;
            r_pbv         <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_target      <= '0;
            r_count       <= '0;
            r_iter        <= '0;
        end else begin
            r_state       <= w_state;
            r_com_adr     <= w_com_adr;
            r_opcode      <= w_opcode;
            r_is_wide     <= w_is_wide;
            r_q_select    <= w_q_select;
            r_param_byte  <= w_param_byte;
            r_param_index <= w_param_index;
            r_pbv         <= w_pbv;
            r_done        <= w_done;
            r_error       <= w_error;
            r_target      <= w_target;
            r_count       <= w_count;
            r_iter        <= w_iter;
        end
    end

endmodule

// File: tb/tb_jvm_decode_sequencer.sv
// tb/tb_jvm_decode_sequencer.sv - directed self-checking bench for jvm_decode_sequencer
module tb_jvm_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        waiting;
    logic        flush;
    logic [7:0]  iram_data;
    logic        iram_valid;
    logic        iram_req;
    logic [2:0]  parameter_number;
    logic [9:0]  next_adr;
    logic [1:0]  state;
    logic [9:0]  com_adr;
    logic [7:0]  jvm_opcode;
    logic        is_wide;
    logic        q_select;
    logic [7:0]  param_byte;
    logic [3:0]  param_index;
    logic        param_byte_valid;
    logic        instr_done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    jvm_decode_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .waiting          (waiting),
        .flush            (flush),
        .iram_data        (iram_data),
        .iram_valid       (iram_valid),
        .iram_req         (iram_req),
        .parameter_number (parameter_number),
        .next_adr         (next_adr),
        .state            (state),
        .com_adr          (com_adr),
        .jvm_opcode       (jvm_opcode),
        .is_wide          (is_wide),
        .q_select         (q_select),
        .param_byte       (param_byte),
        .param_index      (param_index),
        .param_byte_valid (param_byte_valid),
        .instr_done       (instr_done),
        .error            (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (param_byte_valid) strobes++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; waiting = 1'b0; flush = 1'b0;
        iram_data = 8'h00; iram_valid = 1'b0; parameter_number = 3'd0; next_adr = 10'h000;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_com_adr", 32'(com_adr), 0);
        chk("rst_opcode", 32'(jvm_opcode), 0);
        chk("rst_flags", 32'({is_wide, q_select, param_byte_valid, instr_done, error}), 0);
        chk("rst_pbyte", 32'({param_byte, param_index}), 0);
        chk("rst_req", 32'(iram_req), 0);
        reset = 1'b0;
        #1;
        chk("req_fetch", 32'(iram_req), 1);

        // 0-operand opcode, single microstep
        iram_data = 8'h60; iram_valid = 1'b1; parameter_number = 3'd0; next_adr = 10'h000;
        tick();
        chk("t1_state", 32'(state), 2);
        chk("t1_com_adr", 32'(com_adr), 'h060);
        chk("t1_qsel", 32'(q_select), 1);
        chk("t1_opcode", 32'(jvm_opcode), 'h60);
        chk("t1_req_iter", 32'(iram_req), 0);
        iram_valid = 1'b0;
        tick();
        chk("t1_done", 32'(instr_done), 1);
        chk("t1_state2", 32'(state), 0);
        chk("t1_qsel2", 32'(q_select), 0);
        tick();
        chk("t1_done_pulse", 32'(instr_done), 0);

        // one operand byte
        iram_data = 8'h10; iram_valid = 1'b1; parameter_number = 3'd1;
        tick();
        chk("t2_state", 32'(state), 1);
        iram_data = 8'h2A;
        tick();
        chk("t2_pbv", 32'(param_byte_valid), 1);
        chk("t2_pbyte", 32'(param_byte), 'h2A);
        chk("t2_pidx", 32'(param_index), 0);
        chk("t2_state", 32'(state), 2);
        chk("t2_com_adr", 32'(com_adr), 'h010);
        iram_valid = 1'b0;
        tick();
        chk("t2_done", 32'(instr_done), 1);
        chk("t2_pbv_off", 32'(param_byte_valid), 0);

        // wide prefix doubles the operand count
        iram_data = 8'hC4; iram_valid = 1'b1; parameter_number = 3'd1;
        tick();
        chk("t3_wide", 32'(is_wide), 1);
        chk("t3_state_f", 32'(state), 0);
        iram_data = 8'h15;
        tick();
        chk("t3_state_p", 32'(state), 1);
        chk("t3_opcode", 32'(jvm_opcode), 'h15);
        iram_data = 8'h01;
        tick();
        chk("t3_b0", 32'({param_byte_valid, param_byte, param_index}), {1'b1, 8'h01, 4'd0});
        chk("t3_state_p2", 32'(state), 1);
        iram_data = 8'h02;
        tick();
        chk("t3_b1", 32'({param_byte_valid, param_byte, param_index}), {1'b1, 8'h02, 4'd1});
        chk("t3_iter", 32'({state, com_adr}), {2'd2, 10'h015});
        chk("t3_wide_hold", 32'(is_wide), 1);
        iram_valid = 1'b0;
        tick();
        chk("t3_done", 32'(instr_done), 1);
        chk("t3_wide_clr", 32'(is_wide), 0);

        // microcode chain 0x0B6 -> 0x200 -> 0x201 -> end
        iram_data = 8'hB6; iram_valid = 1'b1; parameter_number = 3'd0;
        tick();
        chk("t4_a0", 32'(com_adr), 'h0B6);
        iram_valid = 1'b0; next_adr = 10'h200;
        tick();
        chk("t4_a1", 32'(com_adr), 'h200);
        chk("t4_nodone", 32'(instr_done), 0);
        next_adr = 10'h201;
        tick();
        chk("t4_a2", 32'(com_adr), 'h201);
        next_adr = 10'h000;
        tick();
        chk("t4_done", 32'({state, instr_done}), {2'd0, 1'b1});

        // stall in PARAMS with iram_valid toggling
        iram_data = 8'h20; iram_valid = 1'b1; parameter_number = 3'd2;
        tick();
        iram_data = 8'h11;
        tick();
        chk("t5_b0", 32'({param_byte_valid, param_byte, param_index}), {1'b1, 8'h11, 4'd0});
        waiting = 1'b1; iram_data = 8'h22;
        #1;
        chk("t5_req_stall", 32'(iram_req), 0);
        tick();
        chk("t5_s1", 32'({state, param_byte_valid, param_byte, param_index}), {2'd1, 1'b0, 8'h11, 4'd0});
        iram_valid = 1'b0;
        tick();
        chk("t5_s2", 32'({state, param_byte_valid, param_byte, param_index}), {2'd1, 1'b0, 8'h11, 4'd0});
        iram_valid = 1'b1;
        tick();
        chk("t5_s3", 32'({state, param_byte_valid, param_byte, param_index}), {2'd1, 1'b0, 8'h11, 4'd0});
        waiting = 1'b0;
        tick();
        chk("t5_b1", 32'({param_byte_valid, param_byte, param_index}), {1'b1, 8'h22, 4'd1});
        chk("t5_iter", 32'({state, com_adr}), {2'd2, 10'h020});
        iram_valid = 1'b0;
        tick();
        chk("t5_done", 32'(instr_done), 1);

        // flush in PARAMS after first of two operands
        iram_data = 8'h30; iram_valid = 1'b1; parameter_number = 3'd2;
        tick();
        iram_data = 8'hAA;
        tick();
        chk("t6_b0", 32'({param_byte_valid, param_byte}), {1'b1, 8'hAA});
        flush = 1'b1; iram_data = 8'hBB;
        tick();
        chk("t6_state", 32'(state), 0);
        chk("t6_nostrobe", 32'({param_byte_valid, instr_done, q_select}), 0);
        chk("t6_hold", 32'({param_byte, jvm_opcode, com_adr}), {8'hAA, 8'h30, 10'h020});
        flush = 1'b0; iram_data = 8'h40; parameter_number = 3'd1;
        tick();
        chk("t6_next", 32'({state, jvm_opcode}), {2'd1, 8'h40});
        iram_data = 8'h5C;
        tick();
        chk("t6_nb0", 32'({param_byte_valid, param_byte, param_index}), {1'b1, 8'h5C, 4'd0});
        chk("t6_niter", 32'({state, com_adr}), {2'd2, 10'h040});
        iram_valid = 1'b0;
        tick();
        chk("t6_ndone", 32'(instr_done), 1);
        chk("strobe_total", 32'(strobes), 7);

        // runaway chain trips the watchdog after MAX_ITER steps
        iram_data = 8'h77; iram_valid = 1'b1; parameter_number = 3'd0;
        tick();
        chk("t7_enter", 32'({state, com_adr}), {2'd2, 10'h077});
        iram_valid = 1'b0; next_adr = 10'h300;
        for (int i = 0; i < 63; i++) tick();
        chk("t7_pre", 32'({state, com_adr, error}), {2'd2, 10'h300, 1'b0});
        tick();
        chk("t7_halt", 32'({state, error}), {2'd3, 1'b1});
        chk("t7_req", 32'(iram_req), 0);
        flush = 1'b1; iram_valid = 1'b1;
        tick();
        chk("t7_flush_halt", 32'({state, error}), {2'd3, 1'b1});
        flush = 1'b0;

        // reset out of HALT, then double wide prefix
        reset = 1'b1;
        tick();
        chk("t8_rst", 32'({state, error, com_adr}), 0);
        reset = 1'b0; iram_data = 8'hC4; iram_valid = 1'b1; next_adr = 10'h000;
        tick();
        chk("t8_wide", 32'({state, is_wide}), {2'd0, 1'b1});
        tick();
        chk("t8_dbl", 32'({state, error}), {2'd3, 1'b1});
        iram_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
